// File: rtl/sw_pkg.sv
// Shared types and the XY routing function for the mesh switch allocator.
//   port_e   : output/input port index (N, S, E, W, L)
//   coord_t  : one coordinate, widened to SW_MAX_COORD_W so any COORD_W <= 8 fits
//   addr_t   : {x, y} router address
//   xy_route : dimension-ordered (X first, then Y) route from a destination and local address
package sw_pkg;

    localparam int SW_MAX_COORD_W = 8;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef logic [SW_MAX_COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } addr_t;

    // Unsigned compares; coordinates are zero-extended before they get here.
    function automatic port_e xy_route(input addr_t dest, input addr_t local_a);
        port_e r;
        if (dest.x > local_a.x)      r = PORT_E;
        else if (dest.x < local_a.x) r = PORT_W;
        else if (dest.y > local_a.y) r = PORT_N;
        else if (dest.y < local_a.y) r = PORT_S;
        else                         r = PORT_L;
        return r;
    endfunction

endpackage

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter for one switch output, with optional wormhole lock.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_req[N]      : inputs requesting this output
//   i_tail[N]     : head flit of each input is a tail flit
//   i_full        : downstream buffer of this output is full
//   o_grant[N]    : one-hot winner, all-zero when o_grant_v=0
//   o_grant_v     : a flit crosses this output this cycle
//   o_locked      : output held by an in-flight packet
module rr_lock_arbiter #(
    parameter int N       = 5,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_tail,
    input  logic         i_full,
    output logic [N-1:0] o_grant,
    output logic         o_grant_v,
    output logic         o_locked
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_owner;
    logic          r_locked;

    logic          w_found;
    logic [IW-1:0] w_winner;
    logic [IW-1:0] w_idx;
    logic          w_grant_v;

    // While locked only the owner is considered; otherwise scan from r_ptr upward, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        if (r_locked) begin
            w_found  = i_req[r_owner];
            w_winner = r_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                w_idx = IW'((int'(r_ptr) + k) % N);
                if (!w_found && i_req[w_idx]) begin
                    w_found  = 1'b1;
                    w_winner = w_idx;
                end
            end
        end
    end

    assign w_grant_v = w_found && !i_full && !i_rst;

    always_comb begin
        o_grant = '0;
        for (int j = 0; j < N; j++) begin
            o_grant[j] = w_grant_v && (w_winner == IW'(j));
        end
    end

    assign o_grant_v = w_grant_v;
    assign o_locked  = r_locked;

    // A non-tail grant (re)asserts the lock and leaves the pointer alone; a tail grant
    // releases the lock and advances the pointer past the winner.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr    <= '0;
            r_owner  <= '0;
            r_locked <= 1'b0;
        end else if (w_grant_v) begin
            if (LOCK_EN && !i_tail[w_winner]) begin
                r_locked <= 1'b1;
                r_owner  <= w_winner;
            end else begin
                r_locked <= 1'b0;
                r_ptr    <= (w_winner == IW'(N-1)) ? '0 : w_winner + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator_rr.sv
// Switch allocator for a 2D-mesh router: XY-routes each input's head flit, arbitrates
// every output round-robin (optionally packet-locked) and produces crossbar selects and pops.
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_local_addr        : this router's {x, y}
//   i_packet_addr[i]    : destination {x, y} of input i's head flit
//   i_packet_valid[i]   : input buffer i non-empty
//   i_packet_tail[i]    : head flit of input i is a tail
//   i_buffer_full_in[o] : downstream buffer of output o full
//   o_grant[o][i]       : one-hot input select per output
//   o_grant_v[o]        : output o transfers a flit
//   o_pop_v[i]          : input i dequeued
//   o_locked[o]         : output o held by an in-flight packet
module switch_allocator_rr
    import sw_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int COORD_W   = 4,
    parameter bit LOCK_EN   = 1'b1
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [2*COORD_W-1:0]                   i_local_addr,
    input  logic [NUM_PORTS-1:0][2*COORD_W-1:0]    i_packet_addr,
    input  logic [NUM_PORTS-1:0]                   i_packet_valid,
    input  logic [NUM_PORTS-1:0]                   i_packet_tail,
    input  logic [NUM_PORTS-1:0]                   i_buffer_full_in,
    output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]    o_grant,
    output logic [NUM_PORTS-1:0]                   o_grant_v,
    output logic [NUM_PORTS-1:0]                   o_pop_v,
    output logic [NUM_PORTS-1:0]                   o_locked
);

    function automatic addr_t widen(input logic [2*COORD_W-1:0] a);
        addr_t w;
        w.x = coord_t'(a[2*COORD_W-1:COORD_W]);
        w.y = coord_t'(a[COORD_W-1:0]);
        return w;
    endfunction

    port_e                               w_route [NUM_PORTS];
    logic  [NUM_PORTS-1:0]               w_legal;
    logic  [NUM_PORTS-1:0][NUM_PORTS-1:0] w_req;   // [output][input]
    logic  [NUM_PORTS-1:0][NUM_PORTS-1:0] w_grant; // [output][input]

    // Routes past the last port, or back out of the arrival port, never request.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_route
        assign w_route[i] = xy_route(widen(i_packet_addr[i]), widen(i_local_addr));
        assign w_legal[i] = (int'(w_route[i]) < NUM_PORTS) && (int'(w_route[i]) != i);
        for (genvar o = 0; o < NUM_PORTS; o++) begin : g_req
            assign w_req[o][i] = i_packet_valid[i] && w_legal[i] && (int'(w_route[i]) == o);
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_lock_arbiter #(
            .N       (NUM_PORTS),
            .LOCK_EN (LOCK_EN)
        ) u_arb (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_req     (w_req[o]),
            .i_tail    (i_packet_tail),
            .i_full    (i_buffer_full_in[o]),
            .o_grant   (w_grant[o]),
            .o_grant_v (o_grant_v[o]),
            .o_locked  (o_locked[o])
        );
    end

    assign o_grant = w_grant;

    // Grants are already zero unless valid, so an OR over outputs gives the pops.
    always_comb begin
        o_pop_v = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            o_pop_v = o_pop_v | w_grant[o];
        end
    end

endmodule

// File: tb/tb_switch_allocator_rr.sv
module tb_switch_allocator_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [7:0]      local_addr;
    logic [4:0][7:0] addr;
    logic [4:0]      valid, tail, full;
    logic [4:0][4:0] grant;
    logic [4:0]      gv, pop, locked;

    logic [2:0][7:0] addr2;
    logic [2:0]      valid2, tail2, full2;
    logic [2:0][2:0] grant2;
    logic [2:0]      gv2, pop2, locked2;

    switch_allocator_rr #(.NUM_PORTS(5), .COORD_W(4), .LOCK_EN(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_local_addr(local_addr),
        .i_packet_addr(addr), .i_packet_valid(valid), .i_packet_tail(tail),
        .i_buffer_full_in(full), .o_grant(grant), .o_grant_v(gv),
        .o_pop_v(pop), .o_locked(locked)
    );

    switch_allocator_rr #(.NUM_PORTS(3), .COORD_W(4), .LOCK_EN(1'b1)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_local_addr(local_addr),
        .i_packet_addr(addr2), .i_packet_valid(valid2), .i_packet_tail(tail2),
        .i_buffer_full_in(full2), .o_grant(grant2), .o_grant_v(gv2),
        .o_pop_v(pop2), .o_locked(locked2)
    );

    typedef struct {
        string       name;
        logic [24:0] grant;
        logic [4:0]  gv, pop, locked;
        logic [8:0]  grant2;
        logic [2:0]  gv2, pop2;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: the DUT presents a combinational response every cycle; compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "grant",   32'(grant),   32'(e.grant));
            chk(e.name, "grant_v", 32'(gv),      32'(e.gv));
            chk(e.name, "pop_v",   32'(pop),     32'(e.pop));
            chk(e.name, "locked",  32'(locked),  32'(e.locked));
            chk(e.name, "grant3",  32'(grant2),  32'(e.grant2));
            chk(e.name, "grant_v3",32'(gv2),     32'(e.gv2));
            chk(e.name, "pop_v3",  32'(pop2),    32'(e.pop2));
            chk(e.name, "locked3", 32'(locked2), 32'd0);
        end
    end

    function automatic logic [24:0] G(input int o, input int i);
        logic [24:0] x;
        x = '0;
        x[o*5+i] = 1'b1;
        return x;
    endfunction

    function automatic logic [8:0] G3(input int o, input int i);
        logic [8:0] x;
        x = '0;
        x[o*3+i] = 1'b1;
        return x;
    endfunction

    task automatic cyc(input string nm, input logic r, input logic [4:0][7:0] a,
                       input logic [4:0] v, input logic [4:0] t, input logic [4:0] f,
                       input logic [4:0] egv, input logic [4:0] epop, input logic [24:0] eg,
                       input logic [4:0] elk,
                       input logic [2:0] v2, input logic [2:0] egv2, input logic [2:0] epop2,
                       input logic [8:0] eg2);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; addr = a; valid = v; tail = t; full = f; valid2 = v2;
        e.name = nm; e.grant = eg; e.gv = egv; e.pop = epop; e.locked = elk;
        e.grant2 = eg2; e.gv2 = egv2; e.pop2 = epop2;
        q.push_back(e);
    endtask

    logic [4:0][7:0] a_e, a_par;

    initial begin
        rst = 1'b1;
        local_addr = 8'h22;
        a_e   = {5{8'h32}};
        a_par = {8'h23, 8'h32, 8'h22, 8'h32, 8'h12};
        addr = a_e; valid = '0; tail = '1; full = '0;
        addr2 = {8'h22, 8'h32, 8'h12}; valid2 = '0; tail2 = '1; full2 = '0;

        //   name        rst addr  valid     tail      full      gv        pop       grant                      locked    v2      gv2     pop2    grant3
        cyc("reset",     1, a_e,   5'b11111, 5'b11111, 5'b00000, 5'b00000, 5'b00000, '0,                        5'b00000, 3'b111, 3'b000, 3'b000, '0);
        // Fairness on E: input 2 arrives on E, so it never requests.
        cyc("fair0",     0, a_e,   5'b10111, 5'b11111, 5'b00000, 5'b00100, 5'b00001, G(2,0),                    5'b00000, 3'b000, 3'b000, 3'b000, '0);
        cyc("fair1",     0, a_e,   5'b10111, 5'b11111, 5'b00000, 5'b00100, 5'b00010, G(2,1),                    5'b00000, 3'b000, 3'b000, 3'b000, '0);
        cyc("fair2",     0, a_e,   5'b10111, 5'b11111, 5'b00000, 5'b00100, 5'b10000, G(2,4),                    5'b00000, 3'b000, 3'b000, 3'b000, '0);
        cyc("fair3",     0, a_e,   5'b10111, 5'b11111, 5'b00000, 5'b00100, 5'b00001, G(2,0),                    5'b00000, 3'b000, 3'b000, 3'b000, '0);
        cyc("fair4",     0, a_e,   5'b10111, 5'b11111, 5'b00000, 5'b00100, 5'b00010, G(2,1),                    5'b00000, 3'b000, 3'b000, 3'b000, '0);
        cyc("uturn",     0, a_e,   5'b00100, 5'b11111, 5'b00000, 5'b00000, 5'b00000, '0,                        5'b00000, 3'b000, 3'b000, 3'b000, '0);
        // Backpressure on E, pointer at 2.
        cyc("bp0",       0, a_e,   5'b10000, 5'b11111, 5'b00100, 5'b00000, 5'b00000, '0,                        5'b00000, 3'b000, 3'b000, 3'b000, '0);
        cyc("bp1",       0, a_e,   5'b10000, 5'b11111, 5'b00100, 5'b00000, 5'b00000, '0,                        5'b00000, 3'b000, 3'b000, 3'b000, '0);
        cyc("bp2",       0, a_e,   5'b10000, 5'b11111, 5'b00100, 5'b00000, 5'b00000, '0,                        5'b00000, 3'b000, 3'b000, 3'b000, '0);
        cyc("bp3",       0, a_e,   5'b10000, 5'b11111, 5'b00000, 5'b00100, 5'b10000, G(2,4),                    5'b00000, 3'b000, 3'b000, 3'b000, '0);
        cyc("ptr_wrap",  0, a_e,   5'b10011, 5'b11111, 5'b00000, 5'b00100, 5'b00001, G(2,0),                    5'b00000, 3'b000, 3'b000, 3'b000, '0);
        // Wormhole lock: in0 four flits, in1 single flit contending.
        cyc("lock0",     0, a_e,   5'b00001, 5'b00000, 5'b00000, 5'b00100, 5'b00001, G(2,0),                    5'b00000, 3'b000, 3'b000, 3'b000, '0);
        cyc("lock1",     0, a_e,   5'b00011, 5'b00010, 5'b00000, 5'b00100, 5'b00001, G(2,0),                    5'b00100, 3'b000, 3'b000, 3'b000, '0);
        cyc("lock_gap",  0, a_e,   5'b00010, 5'b00010, 5'b00000, 5'b00000, 5'b00000, '0,                        5'b00100, 3'b000, 3'b000, 3'b000, '0);
        cyc("lock2",     0, a_e,   5'b00011, 5'b00010, 5'b00000, 5'b00100, 5'b00001, G(2,0),                    5'b00100, 3'b000, 3'b000, 3'b000, '0);
        cyc("lock3",     0, a_e,   5'b00011, 5'b00011, 5'b00000, 5'b00100, 5'b00001, G(2,0),                    5'b00100, 3'b000, 3'b000, 3'b000, '0);
        cyc("lock_rel",  0, a_e,   5'b00010, 5'b00010, 5'b00000, 5'b00100, 5'b00010, G(2,1),                    5'b00000, 3'b000, 3'b000, 3'b000, '0);
        // Disjoint outputs in parallel: N<-in4, W<-in0, L<-in2.
        cyc("parallel",  0, a_par, 5'b10101, 5'b11111, 5'b00000, 5'b11001, 5'b10101, G(3,0)|G(4,2)|G(0,4),      5'b00000, 3'b000, 3'b000, 3'b000, '0);
        // Three-port instance: W and L routes are illegal there.
        cyc("p3_west",   0, a_e,   5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b00000, '0,                        5'b00000, 3'b001, 3'b000, 3'b000, '0);
        cyc("p3_east",   0, a_e,   5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b00000, '0,                        5'b00000, 3'b010, 3'b100, 3'b010, G3(2,1));
        cyc("p3_local",  0, a_e,   5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b00000, '0,                        5'b00000, 3'b100, 3'b000, 3'b000, '0);
        cyc("p3_all",    0, a_e,   5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b00000, '0,                        5'b00000, 3'b111, 3'b100, 3'b010, G3(2,1));
        // Reset in the middle of a locked packet; E pointer is 2 beforehand.
        cyc("mid_head",  0, a_e,   5'b00001, 5'b00000, 5'b00000, 5'b00100, 5'b00001, G(2,0),                    5'b00000, 3'b000, 3'b000, 3'b000, '0);
        cyc("mid_rst",   1, a_e,   5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, '0,                        5'b00000, 3'b111, 3'b000, 3'b000, '0);
        cyc("mid_after", 0, a_e,   5'b01010, 5'b01010, 5'b00000, 5'b00100, 5'b00010, G(2,1),                    5'b00000, 3'b000, 3'b000, 3'b000, '0);
        cyc("mid_next",  0, a_e,   5'b01000, 5'b01000, 5'b00000, 5'b00100, 5'b01000, G(2,3),                    5'b00000, 3'b000, 3'b000, 3'b000, '0);

        for (int n = 0; n < 10 && q.size() != 0; n++) @(negedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
